// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares one single-port synchronous memory between the core's
// instruction-fetch port and data port.
//
// Arbitration is combinational with one grant per cycle. The data port wins
// conflicts unless fetch has been denied STARVE_MAX consecutive cycles, in
// which case fetch is forced through. Read data is steered back using a
// RD_LAT-deep {valid, owner} tag pipeline that matches the memory latency.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt    fetch request channel
//   if_rvalid/if_rdata          fetch read response
//   d_req/d_we/d_addr/d_wdata   data request channel -> d_gnt
//   d_rvalid/d_rdata            data read response (reads only)
//   mem_en/we/addr/wdata        memory request, mem_rdata RD_LAT cycles later
//   perf_conflicts              cycles with both requests present
//   perf_starve_wins            conflicts won by fetch via the starvation guard
//
// Build option: define RV_MEM_ARB_PERF_EN to build the two performance
// counters; otherwise both perf outputs are tied to zero.

module rv_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_conflicts,
  output logic [31:0]       perf_starve_wins
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_own_q, tag_own_d;
  logic              arb_if, arb_d;

  // Raw arbitration result. State updates use it directly; only the visible
  // grants are masked by rst_n, since all flops are held in reset anyway.
  always_comb begin
    arb_if = 1'b0;
    arb_d  = 1'b0;
    if (if_req && d_req) begin
      arb_if = (starve_cnt_q == STARVE_LIM);
      arb_d  = !arb_if;
    end else begin
      arb_if = if_req;
      arb_d  = d_req;
    end
  end

  assign if_gnt = arb_if & rst_n;
  assign d_gnt  = arb_d & rst_n;

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (if_req && !arb_if) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q
                                                  : starve_cnt_q + SW'(1);
    end
  end

  // Stage 0 captures the access issued this cycle; the last stage lines up
  // with mem_rdata. Writes enter as invalid so they never raise rvalid.
  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = arb_if | (arb_d & ~d_we);
    tag_own_d[0] = arb_d;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      tag_vld_q    <= '0;
      tag_own_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_vld_q    <= tag_vld_d;
      tag_own_q    <= tag_own_d;
    end
  end

  assign if_rvalid = tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
  assign d_rvalid  = tag_vld_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

`ifdef RV_MEM_ARB_PERF_EN
  logic [31:0] perf_conf_q, perf_conf_d;
  logic [31:0] perf_win_q, perf_win_d;

  always_comb begin
    perf_conf_d = perf_conf_q;
    perf_win_d  = perf_win_q;
    if (if_req && d_req) begin
      perf_conf_d = perf_conf_q + 32'd1;
      if (arb_if) perf_win_d = perf_win_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conf_q <= '0;
      perf_win_q  <= '0;
    end else begin
      perf_conf_q <= perf_conf_d;
      perf_win_q  <= perf_win_d;
    end
  end

  assign perf_conflicts   = perf_conf_q;
  assign perf_starve_wins = perf_win_q;
`else
  assign perf_conflicts   = '0;
  assign perf_starve_wins = '0;
`endif

endmodule

// File: tb/tb_rv_mem_arb.sv
// Testbench for rv_mem_arb. Three arbiters (RD_LAT = 1, 2, 3, STARVE_MAX = 4)
// share one directed stimulus stream; each has its own memory and its own
// reference model (arbitration rules, response queue, reference memory,
// perf counts) checked every cycle, plus literal expectations per scenario.
// Perf expectations follow RV_MEM_ARB_PERF_EN when it is defined.

module tb_rv_mem_arb;

  localparam int SMAX = 4;
  localparam int NI   = 3;
`ifdef RV_MEM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    int          due;
    bit          owner;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  int checks   = 0;
  int failures = 0;

  logic [NI-1:0] if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, mem_we_a, mem_en_a;
  logic [31:0]   if_rdata_a [NI];
  logic [31:0]   d_rdata_a  [NI];
  logic [31:0]   perf_c_a   [NI];
  logic [31:0]   perf_s_a   [NI];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_lat
    localparam int LAT = g + 1;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata, perf_c, perf_s;

    rv_mem_arb #(
      .ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .STARVE_MAX(SMAX)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .perf_conflicts(perf_c), .perf_starve_wins(perf_s)
    );

    assign if_gnt_a[g]    = if_gnt;
    assign d_gnt_a[g]     = d_gnt;
    assign if_rvalid_a[g] = if_rvalid;
    assign d_rvalid_a[g]  = d_rvalid;
    assign mem_we_a[g]    = mem_we;
    assign mem_en_a[g]    = mem_en;
    assign if_rdata_a[g]  = if_rdata;
    assign d_rdata_a[g]   = d_rdata;
    assign perf_c_a[g]    = perf_c;
    assign perf_s_a[g]    = perf_s;

    // Memory: an unwritten word at byte address A reads as A/4.
    logic [31:0] store [int unsigned];
    logic [31:0] rd_pipe [LAT];
    assign mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin : mem_model
      int unsigned k;
      k = {2'b00, mem_addr[31:2]};
      if (mem_en && mem_we) store[k] = mem_wdata;
      rd_pipe[0] <= (mem_en && !mem_we) ? (store.exists(k) ? store[k] : k) : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference model and per-cycle compare.
    rsp_t        q [$];
    logic [31:0] ref_mem [int unsigned];
    int          cyc    = 0;
    int          denied = 0;
    logic [31:0] m_conf = '0;
    logic [31:0] m_win  = '0;

    always @(negedge clk) begin : cmp
      bit          eg_if, eg_d, due_now;
      logic [31:0] ea;
      int unsigned k;
      rsp_t        r;
      cyc++;
      eg_if = 1'b0;
      eg_d  = 1'b0;
      if (!rst_n) begin
        q.delete();
        denied = 0;
        m_conf = '0;
        m_win  = '0;
      end else if (if_req && d_req) begin
        eg_if = (denied >= SMAX);
        eg_d  = !eg_if;
      end else begin
        eg_if = if_req;
        eg_d  = d_req;
      end
      ea = eg_if ? if_addr : (eg_d ? d_addr : 32'h0);

      check($sformatf("L%0d if_gnt c%0d", LAT, cyc), 32'(if_gnt), 32'(eg_if));
      check($sformatf("L%0d d_gnt c%0d", LAT, cyc), 32'(d_gnt), 32'(eg_d));
      check($sformatf("L%0d mem_en c%0d", LAT, cyc), 32'(mem_en), 32'(eg_if | eg_d));
      check($sformatf("L%0d mem_we c%0d", LAT, cyc), 32'(mem_we), 32'(eg_d && d_we));
      check($sformatf("L%0d mem_addr c%0d", LAT, cyc), mem_addr, ea);
      if (!eg_if)
        check($sformatf("L%0d mem_wdata c%0d", LAT, cyc), mem_wdata, eg_d ? d_wdata : 32'h0);

      due_now = (q.size() > 0) && (q[0].due == cyc);
      check($sformatf("L%0d if_rvalid c%0d", LAT, cyc), 32'(if_rvalid), 32'(due_now && !q[0].owner));
      check($sformatf("L%0d d_rvalid c%0d", LAT, cyc), 32'(d_rvalid), 32'(due_now && q[0].owner));
      if (due_now) begin
        r = q.pop_front();
        if (r.owner) check($sformatf("L%0d d_rdata c%0d", LAT, cyc), d_rdata, r.data);
        else         check($sformatf("L%0d if_rdata c%0d", LAT, cyc), if_rdata, r.data);
      end
      check($sformatf("L%0d perf_conflicts c%0d", LAT, cyc), perf_c, PERF ? m_conf : 32'h0);
      check($sformatf("L%0d perf_starve_wins c%0d", LAT, cyc), perf_s, PERF ? m_win : 32'h0);

      if (rst_n) begin
        if (if_req && d_req) begin
          m_conf++;
          if (eg_if) m_win++;
        end
        denied = (if_req && !eg_if) ? denied + 1 : 0;
        if (eg_if) begin
          k = {2'b00, if_addr[31:2]};
          r.due = cyc + LAT; r.owner = 1'b0;
          r.data = ref_mem.exists(k) ? ref_mem[k] : k;
          q.push_back(r);
        end
        if (eg_d) begin
          k = {2'b00, d_addr[31:2]};
          if (d_we) ref_mem[k] = d_wdata;
          else begin
            r.due = cyc + LAT; r.owner = 1'b1;
            r.data = ref_mem.exists(k) ? ref_mem[k] : k;
            q.push_back(r);
          end
        end
      end
    end
  end

  task automatic cyc_in(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                        input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset with both requests asserted: everything must stay quiet.
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h0;
    @(negedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      check("rst if_gnt", 32'(if_gnt_a[i]), 32'h0);
      check("rst d_gnt", 32'(d_gnt_a[i]), 32'h0);
      check("rst mem_en", 32'(mem_en_a[i]), 32'h0);
      check("rst if_rvalid", 32'(if_rvalid_a[i]), 32'h0);
      check("rst perf", perf_c_a[i], 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk); #1;

    // Fetch-only reads 0x0, 0x4, 0x8 on consecutive cycles.
    cyc_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t1 gnt0", 32'(if_gnt_a[0]), 32'h1);
    cyc_in(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t1 gnt1", 32'(if_gnt_a[0]), 32'h1);
    check("t1 rv0", 32'(if_rvalid_a[0]), 32'h1);
    check("t1 rd0", if_rdata_a[0], 32'h0);
    cyc_in(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t1 gnt2", 32'(if_gnt_a[0]), 32'h1);
    check("t1 rd1", if_rdata_a[0], 32'h1);
    idle(1);
    check("t1 rv2", 32'(if_rvalid_a[0]), 32'h1);
    check("t1 rd2", if_rdata_a[0], 32'h2);
    check("t1 d_rvalid", 32'(d_rvalid_a[0]), 32'h0);
    idle(3);

    // Data write then read-back.
    cyc_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hCAFE_BABE);
    check("t2 wr gnt", 32'(d_gnt_a[0]), 32'h1);
    check("t2 wr we", 32'(mem_we_a[0]), 32'h1);
    cyc_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
    check("t2 rd we", 32'(mem_we_a[0]), 32'h0);
    check("t2 wr no rvalid", 32'(d_rvalid_a[0]), 32'h0);
    idle(1);
    check("t2 rvalid", 32'(d_rvalid_a[0]), 32'h1);
    check("t2 rdata", d_rdata_a[0], 32'hCAFE_BABE);
    idle(3);

    // Both requests held: data x4, then fetch, repeating.
    for (int k = 0; k < 10; k++) begin
      cyc_in(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
      check($sformatf("t3 if_gnt k%0d", k), 32'(if_gnt_a[0]), 32'((k == 4) || (k == 9)));
      check($sformatf("t3 d_gnt k%0d", k), 32'(d_gnt_a[0]), 32'(!((k == 4) || (k == 9))));
    end
    idle(1);
    check("t3 perf_conflicts", perf_c_a[0], PERF ? 32'd10 : 32'd0);
    check("t3 perf_starve_wins", perf_s_a[0], PERF ? 32'd2 : 32'd0);
    idle(3);

    // RD_LAT=3: fetch, data read, data write, fetch.
    cyc_in(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
    cyc_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'h1234_5678);
    cyc_in(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t4 if rv a", 32'(if_rvalid_a[2]), 32'h1);
    check("t4 if rd a", if_rdata_a[2], 32'h3);
    idle(1);
    check("t4 d rv", 32'(d_rvalid_a[2]), 32'h1);
    check("t4 d rd", d_rdata_a[2], 32'hCAFE_BABE);
    idle(1);
    check("t4 wr none if", 32'(if_rvalid_a[2]), 32'h0);
    check("t4 wr none d", 32'(d_rvalid_a[2]), 32'h0);
    idle(1);
    check("t4 if rv b", 32'(if_rvalid_a[2]), 32'h1);
    check("t4 if rd b", if_rdata_a[2], 32'h4);
    idle(2);

    // RD_LAT=2: reset pulse one cycle after a read grant.
    cyc_in(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t5 gnt", 32'(if_gnt_a[1]), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40; d_addr = 32'h80;
    @(negedge clk); #1;
    check("t5 rst if_gnt", 32'(if_gnt_a[1]), 32'h0);
    check("t5 rst d_gnt", 32'(d_gnt_a[1]), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk); #1;
    check("t5 dropped rvalid", 32'(if_rvalid_a[1]), 32'h0);
    check("t5 d_rvalid", 32'(d_rvalid_a[1]), 32'h0);
    check("t5 mem_en", 32'(mem_en_a[1]), 32'h0);
    check("t5 perf", perf_c_a[1], 32'h0);
    idle(1);
    check("t5 late rvalid", 32'(if_rvalid_a[1]), 32'h0);
    cyc_in(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t5 new gnt", 32'(if_gnt_a[1]), 32'h1);
    idle(2);
    check("t5 new rvalid", 32'(if_rvalid_a[1]), 32'h1);
    check("t5 new rdata", if_rdata_a[1], 32'h6);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
